// File: rtl/alu_arbiter_if.sv
// Request, ALU-side and response bundle for alu_arbiter.
// Ports: per-requester req* vectors (slice i per requester),
//   alu* operands/control out and aluResult back,
//   rsp* registered response with valid/ready.
// slave = the arbiter; master = requesters, ALU and consumer.
interface alu_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 3
);
   logic [NUM_REQ-1:0]    reqValid;
   logic [NUM_REQ-1:0]    reqReady;
   logic [2*NUM_REQ-1:0]  reqAluOp;
   logic [6*NUM_REQ-1:0]  reqFunct;
   logic [5*NUM_REQ-1:0]  reqShamt;
   logic [32*NUM_REQ-1:0] reqA;
   logic [32*NUM_REQ-1:0] reqB;

   logic [31:0] aluIn1;
   logic [31:0] aluIn2;
   logic [4:0]  aluShamt;
   logic [3:0]  aluControlOut;
   logic [31:0] aluResult;

   logic            rspValid;
   logic            rspReady;
   logic [ID_W-1:0] rspId;
   logic [31:0]     rspData;
   logic            rspIllegal;
   logic            rspOverflow;

   modport slave (
      input  reqValid, reqAluOp, reqFunct, reqShamt,
      input  reqA, reqB, aluResult, rspReady,
      output reqReady, aluIn1, aluIn2, aluShamt,
      output aluControlOut, rspValid, rspId, rspData,
      output rspIllegal, rspOverflow
   );

   modport master (
      output reqValid, reqAluOp, reqFunct, reqShamt,
      output reqA, reqB, aluResult, rspReady,
      input  reqReady, aluIn1, aluIn2, aluShamt,
      input  aluControlOut, rspValid, rspId, rspData,
      input  rspIllegal, rspOverflow
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between
// NUM_REQ requesters: IDLE grants and latches, EXEC drives the
// ALU and captures the result, RESP holds it until accepted.
// Ports: clk, reset (sync, active-high), bus (alu_arbiter_if.slave).
// Optional macro ALU_OVF_CHECK_EN: signed overflow on add/sub
// into rspOverflow; without it rspOverflow is constant 0.
module alu_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 3
) (
   input logic          clk,
   input logic          reset,
   alu_arbiter_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

   logic [1:0]      state_q, state_d;
   logic [ID_W-1:0] last_q, last_d;
   logic [ID_W-1:0] gnt_id_q, gnt_id_d;

   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic [4:0]  op_sh_q, op_sh_d;
   logic [3:0]  op_code_q, op_code_d;
   logic        op_ill_q, op_ill_d;

   logic            rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [31:0]     rsp_data_q, rsp_data_d;
   logic            rsp_ill_q, rsp_ill_d;

   logic               found;
   logic [ID_W-1:0]    pick;
   logic [NUM_REQ-1:0] gnt_oh;
   logic [1:0]         sel_op;
   logic [5:0]         sel_funct;
   logic [4:0]         sel_sh;
   logic [31:0]        sel_a;
   logic [31:0]        sel_b;

   logic [3:0] dec_code;
   logic       dec_ill;

   // Pass 0 looks only above lastGrant, pass 1 wraps to 0,
   // giving a rotating priority starting at lastGrant+1.
   always_comb begin
      found     = 1'b0;
      pick      = '0;
      gnt_oh    = '0;
      sel_op    = '0;
      sel_funct = '0;
      sel_sh    = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.reqValid[i] &&
                (p == 1 || i > int'(last_q))) begin
               found     = 1'b1;
               pick      = ID_W'(i);
               gnt_oh[i] = 1'b1;
               sel_op    = bus.reqAluOp[2*i +: 2];
               sel_funct = bus.reqFunct[6*i +: 6];
               sel_sh    = bus.reqShamt[5*i +: 5];
               sel_a     = bus.reqA[32*i +: 32];
               sel_b     = bus.reqB[32*i +: 32];
            end
         end
      end
   end

   always_comb begin
      dec_code = 4'd0;
      dec_ill  = 1'b0;
      unique case (sel_op)
         2'd0: dec_code = 4'd0;
         2'd1: dec_code = 4'd2;
         2'd3: dec_code = 4'd1;
         2'd2: begin
            case (sel_funct)
               6'h20:   dec_code = 4'd0;
               6'h22:   dec_code = 4'd1;
               6'h24:   dec_code = 4'd2;
               6'h25:   dec_code = 4'd3;
               6'h00:   dec_code = 4'd4;
               6'h02:   dec_code = 4'd5;
               6'h03:   dec_code = 4'd6;
               6'h2A:   dec_code = 4'd8;
               default: dec_ill  = 1'b1;
            endcase
         end
         default: dec_code = 4'd0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt_id_d    = gnt_id_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_sh_d     = op_sh_q;
      op_code_d   = op_code_q;
      op_ill_d    = op_ill_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_ill_d   = rsp_ill_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               last_d    = pick;
               gnt_id_d  = pick;
               op_a_d    = sel_a;
               op_b_d    = sel_b;
               op_sh_d   = sel_sh;
               op_code_d = dec_code;
               op_ill_d  = dec_ill;
               state_d   = S_EXEC;
            end
         end
         S_EXEC: begin
            rsp_data_d  = op_ill_q ? 32'd0 : bus.aluResult;
            rsp_id_d    = gnt_id_q;
            rsp_ill_d   = op_ill_q;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (bus.rspReady) begin
               rsp_valid_d = 1'b0;
               rsp_ill_d   = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         last_q      <= LAST_RST;
         gnt_id_q    <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_sh_q     <= '0;
         op_code_q   <= '0;
         op_ill_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_ill_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_id_q    <= gnt_id_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_sh_q     <= op_sh_d;
         op_code_q   <= op_code_d;
         op_ill_q    <= op_ill_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_ill_q   <= rsp_ill_d;
      end
   end

`ifdef ALU_OVF_CHECK_EN
   logic ovf_now;
   logic rsp_ovf_q, rsp_ovf_d;

   always_comb begin
      ovf_now = 1'b0;
      if (!op_ill_q) begin
         case (op_code_q)
            4'd0: ovf_now = (op_a_q[31] == op_b_q[31]) &&
                            (bus.aluResult[31] != op_a_q[31]);
            4'd1: ovf_now = (op_a_q[31] != op_b_q[31]) &&
                            (bus.aluResult[31] != op_a_q[31]);
            default: ovf_now = 1'b0;
         endcase
      end
   end

   always_comb begin
      rsp_ovf_d = rsp_ovf_q;
      if (state_q == S_EXEC) begin
         rsp_ovf_d = ovf_now;
      end else if (state_q == S_RESP && bus.rspReady) begin
         rsp_ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_ovf_q <= 1'b0;
      end else begin
         rsp_ovf_q <= rsp_ovf_d;
      end
   end

   assign bus.rspOverflow = rsp_ovf_q;
`else
   assign bus.rspOverflow = 1'b0;
`endif

   // Grant strobe is combinational and only meaningful in IDLE.
   assign bus.reqReady = (!reset && state_q == S_IDLE) ?
                         gnt_oh : '0;

   assign bus.aluIn1        = op_a_q;
   assign bus.aluIn2        = op_b_q;
   assign bus.aluShamt      = op_sh_q;
   assign bus.aluControlOut = op_code_q;

   assign bus.rspValid   = rsp_valid_q;
   assign bus.rspId      = rsp_id_q;
   assign bus.rspData    = rsp_data_q;
   assign bus.rspIllegal = rsp_ill_q;

endmodule
